// File: rtl/axi_fft_ram_bridge_pkg.sv
// Shared types and encodings for the AXI4 FFT sample RAM bridge.
package axi_fft_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD      = 2'd3
  } bridge_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_fft_ram_bridge_if.sv
// AXI4 channels between host and FFT RAM bridge; slave modport is the bridge side.
interface axi_fft_ram_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 2
);
  logic [ADDR_WIDTH-1:0]   i_AWADDR;
  logic [7:0]              i_AWLEN;
  logic [2:0]              i_AWSIZE;
  logic [1:0]              i_AWBURST;
  logic [ID_WIDTH-1:0]     i_AWID;
  logic                    i_AWVALID;
  logic                    o_AWREADY;

  logic [DATA_WIDTH-1:0]   i_WDATA;
  logic [DATA_WIDTH/8-1:0] i_WSTRB;
  logic                    i_WVALID;
  logic                    i_WLAST;
  logic                    o_WREADY;

  logic                    o_BVALID;
  logic [ID_WIDTH-1:0]     o_BID;
  logic [1:0]              o_BRESP;
  logic                    i_BREADY;

  logic [ADDR_WIDTH-1:0]   i_ARADDR;
  logic [7:0]              i_ARLEN;
  logic [2:0]              i_ARSIZE;
  logic [1:0]              i_ARBURST;
  logic [ID_WIDTH-1:0]     i_ARID;
  logic                    i_ARVALID;
  logic                    o_ARREADY;

  logic                    o_RVALID;
  logic                    o_RLAST;
  logic [DATA_WIDTH-1:0]   o_RDATA;
  logic [ID_WIDTH-1:0]     o_RID;
  logic [1:0]              o_RRESP;
  logic                    i_RREADY;

  modport slave (
    input  i_AWADDR, i_AWLEN, i_AWSIZE, i_AWBURST, i_AWID, i_AWVALID,
    output o_AWREADY,
    input  i_WDATA, i_WSTRB, i_WVALID, i_WLAST,
    output o_WREADY,
    output o_BVALID, o_BID, o_BRESP,
    input  i_BREADY,
    input  i_ARADDR, i_ARLEN, i_ARSIZE, i_ARBURST, i_ARID, i_ARVALID,
    output o_ARREADY,
    output o_RVALID, o_RLAST, o_RDATA, o_RID, o_RRESP,
    input  i_RREADY
  );

  modport master (
    output i_AWADDR, i_AWLEN, i_AWSIZE, i_AWBURST, i_AWID, i_AWVALID,
    input  o_AWREADY,
    output i_WDATA, i_WSTRB, i_WVALID, i_WLAST,
    input  o_WREADY,
    input  o_BVALID, o_BID, o_BRESP,
    output i_BREADY,
    output i_ARADDR, i_ARLEN, i_ARSIZE, i_ARBURST, i_ARID, i_ARVALID,
    input  o_ARREADY,
    input  o_RVALID, o_RLAST, o_RDATA, o_RID, o_RRESP,
    output i_RREADY
  );

endinterface

// File: rtl/axi_rd_skid.sv
// Two-entry FIFO decoupling the 1-clk RAM read return from R-channel backpressure.
module axi_rd_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic [1:0]            i_resp,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_resp,
  output logic [1:0]            o_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [1:0]            resp;
  } ent_t;

  ent_t [1:0] mem_q, mem_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;
  ent_t       head;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = i_pop && (cnt_q != 2'd0);
    do_push  = i_push && ((cnt_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = '{data: i_data, last: i_last, resp: i_resp};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign o_valid = (cnt_q != 2'd0);
  assign o_data  = head.data;
  assign o_last  = head.last;
  assign o_resp  = head.resp;
  assign o_count = cnt_q;

endmodule

// File: rtl/axi_fft_ram_bridge.sv
// AXI4 slave loading FFT samples into RAM and streaming results back after i_CALC_END.
// Optional FFT_BRIDGE_RANGE_CHECK_EN: beats at index >= i_SAMPLES_NUMBER skip the RAM and answer SLVERR.
module axi_fft_ram_bridge
  import axi_fft_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int IDX_WIDTH  = 10,
  parameter int ID_WIDTH   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  axi_fft_ram_bridge_if.slave     axi,
  input  logic                    i_CALC_END,
  input  logic [IDX_WIDTH:0]      i_SAMPLES_NUMBER,
  output logic                    o_DATA_LOADED,
  output logic                    o_WRITE_ram,
  output logic                    o_READ_ram,
  output logic [IDX_WIDTH-1:0]    o_SAMPLE_INDEX_ram,
  output logic [DATA_WIDTH-1:0]   o_SAMPLE_ram,
  output logic [DATA_WIDTH/8-1:0] o_WSTRB_ram,
  input  logic [DATA_WIDTH-1:0]   i_DATA_FROM_RAM
);

  localparam int         SHIFT   = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] SIZE_OK = 3'(SHIFT);

  bridge_state_e         state_q, state_d;
  logic                  calc_done_q, calc_done_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic                  fixed_q, fixed_d;
  logic                  err_q, err_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [8:0]            issued_q, issued_d;
  // One RAM read in flight: its data is on i_DATA_FROM_RAM in the following cycle.
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  logic                  infl_err_q, infl_err_d;

  logic                  cur_oor, beat_err, last_beat, wlast_bad;
  logic [2:0]            occ;
  logic                  skid_pop, skid_valid, skid_last;
  logic [DATA_WIDTH-1:0] skid_data, push_data;
  logic [1:0]            skid_resp, skid_cnt, push_resp;

`ifdef FFT_BRIDGE_RANGE_CHECK_EN
  assign cur_oor = ({1'b0, idx_q} >= i_SAMPLES_NUMBER);
`else
  logic unused_samples;
  assign cur_oor        = 1'b0;
  assign unused_samples = ^i_SAMPLES_NUMBER;
`endif

  assign push_data = infl_err_q ? '0 : i_DATA_FROM_RAM;
  assign push_resp = infl_err_q ? RESP_SLVERR : RESP_OKAY;

  axi_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (infl_q),
    .i_data  (push_data),
    .i_last  (infl_last_q),
    .i_resp  (push_resp),
    .i_pop   (skid_pop),
    .o_valid (skid_valid),
    .o_data  (skid_data),
    .o_last  (skid_last),
    .o_resp  (skid_resp),
    .o_count (skid_cnt)
  );

  always_comb begin
    state_d     = state_q;
    calc_done_d = calc_done_q | i_CALC_END;
    id_d        = id_q;
    idx_d       = idx_q;
    len_d       = len_q;
    fixed_d     = fixed_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;
    issued_d    = issued_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    infl_err_d  = 1'b0;
    beat_err    = err_q | cur_oor;
    last_beat   = (beat_cnt_q == len_q);
    wlast_bad   = 1'b0;
    occ         = 3'd0;
    skid_pop    = 1'b0;

    axi.o_AWREADY      = 1'b0;
    axi.o_ARREADY      = 1'b0;
    axi.o_WREADY       = 1'b0;
    axi.o_BVALID       = 1'b0;
    axi.o_BRESP        = RESP_OKAY;
    o_DATA_LOADED      = 1'b0;
    o_WRITE_ram        = 1'b0;
    o_READ_ram         = 1'b0;
    o_SAMPLE_INDEX_ram = '0;
    o_SAMPLE_ram       = '0;
    o_WSTRB_ram        = '0;

    unique case (state_q)
      IDLE: begin
        axi.o_AWREADY = 1'b1;
        axi.o_ARREADY = calc_done_q & ~axi.i_AWVALID;
        if (axi.i_AWVALID) begin
          id_d       = axi.i_AWID;
          idx_d      = IDX_WIDTH'(axi.i_AWADDR >> SHIFT);
          len_d      = axi.i_AWLEN;
          fixed_d    = (axi.i_AWBURST == BURST_FIXED);
          err_d      = (axi.i_AWBURST == BURST_WRAP) || (axi.i_AWSIZE != SIZE_OK);
          beat_cnt_d = 8'd0;
          state_d    = WR_DATA;
        end else if (axi.i_ARVALID && calc_done_q) begin
          id_d     = axi.i_ARID;
          idx_d    = IDX_WIDTH'(axi.i_ARADDR >> SHIFT);
          len_d    = axi.i_ARLEN;
          fixed_d  = (axi.i_ARBURST == BURST_FIXED);
          err_d    = (axi.i_ARBURST == BURST_WRAP) || (axi.i_ARSIZE != SIZE_OK);
          issued_d = 9'd0;
          state_d  = RD;
        end
      end

      WR_DATA: begin
        axi.o_WREADY = 1'b1;
        if (axi.i_WVALID) begin
          o_SAMPLE_INDEX_ram = idx_q;
          o_SAMPLE_ram       = axi.i_WDATA;
          o_WSTRB_ram        = axi.i_WSTRB;
          o_WRITE_ram        = ~beat_err;
          // Early or missing WLAST poisons the response; the beat count still decides where the burst ends.
          wlast_bad  = (axi.i_WLAST != last_beat);
          err_d      = beat_err | wlast_bad;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (!fixed_q) idx_d = idx_q + 1'b1;
          if (last_beat) begin
            state_d       = WR_RESP;
            o_DATA_LOADED = ~(beat_err | wlast_bad);
            if (!(beat_err | wlast_bad)) calc_done_d = i_CALC_END;
          end
        end
      end

      WR_RESP: begin
        axi.o_BVALID = 1'b1;
        axi.o_BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi.i_BREADY) state_d = IDLE;
      end

      RD: begin
        skid_pop = skid_valid & axi.i_RREADY;
        // Slots already claimed after this cycle's pop; keeps the skid from ever overflowing.
        occ = {1'b0, skid_cnt} + {2'b0, infl_q} - {2'b0, skid_pop};
        if ((issued_q <= {1'b0, len_q}) && (occ < 3'd2)) begin
          infl_d             = 1'b1;
          infl_last_d        = (issued_q[7:0] == len_q);
          infl_err_d         = beat_err;
          o_READ_ram         = ~beat_err;
          o_SAMPLE_INDEX_ram = idx_q;
          issued_d           = issued_q + 9'd1;
          if (!fixed_q) idx_d = idx_q + 1'b1;
        end
        if (skid_pop && skid_last) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    axi.o_RVALID = skid_valid;
    axi.o_RLAST  = skid_valid & skid_last;
    axi.o_RDATA  = skid_valid ? skid_data : '0;
    axi.o_RRESP  = skid_valid ? skid_resp : RESP_OKAY;
    axi.o_RID    = id_q;
    axi.o_BID    = id_q;

    // Hold every output quiet while reset is asserted, even before the clearing edge.
    if (!i_rstn) begin
      axi.o_AWREADY      = 1'b0;
      axi.o_ARREADY      = 1'b0;
      axi.o_WREADY       = 1'b0;
      axi.o_BVALID       = 1'b0;
      axi.o_BRESP        = RESP_OKAY;
      axi.o_RVALID       = 1'b0;
      axi.o_RLAST        = 1'b0;
      axi.o_RDATA        = '0;
      axi.o_RRESP        = RESP_OKAY;
      axi.o_RID          = '0;
      axi.o_BID          = '0;
      o_DATA_LOADED      = 1'b0;
      o_WRITE_ram        = 1'b0;
      o_READ_ram         = 1'b0;
      o_SAMPLE_INDEX_ram = '0;
      o_SAMPLE_ram       = '0;
      o_WSTRB_ram        = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      calc_done_q <= 1'b0;
      id_q        <= '0;
      idx_q       <= '0;
      len_q       <= 8'd0;
      fixed_q     <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= 8'd0;
      issued_q    <= 9'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      calc_done_q <= calc_done_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      fixed_q     <= fixed_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
      issued_q    <= issued_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      infl_err_q  <= infl_err_d;
    end
  end

endmodule

// File: tb/tb_axi_fft_ram_bridge.sv
// Directed bench for axi_fft_ram_bridge with a byte-strobed RAM model behind it.
module tb_axi_fft_ram_bridge;
  import axi_fft_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        calc_end;
  logic [10:0] samples_number;
  logic        data_loaded, write_ram, read_ram;
  logic [9:0]  sample_index;
  logic [31:0] sample_data;
  logic [3:0]  wstrb_ram;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:1023];
  logic        ram_clr;
  int          wr_count = 0;
  int          rd_count = 0;

  // write_burst results
  logic [1:0]  wb_bresp;
  logic [1:0]  wb_bid;
  int          wb_loaded_cnt, wb_loaded_beat, wb_writes;
  // read_burst results
  logic [31:0] rb_data [0:15];
  logic        rb_last [0:15];
  logic [1:0]  rb_resp [0:15];
  logic [1:0]  rb_id   [0:15];
  int          rb_cyc  [0:15];
  int          rb_n, rb_reads, rb_max_out;

  always #5 clk = ~clk;

  axi_fft_ram_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ID_WIDTH(2)) axi ();

  axi_fft_ram_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .IDX_WIDTH(10), .ID_WIDTH(2)) dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .axi                (axi),
    .i_CALC_END         (calc_end),
    .i_SAMPLES_NUMBER   (samples_number),
    .o_DATA_LOADED      (data_loaded),
    .o_WRITE_ram        (write_ram),
    .o_READ_ram         (read_ram),
    .o_SAMPLE_INDEX_ram (sample_index),
    .o_SAMPLE_ram       (sample_data),
    .o_WSTRB_ram        (wstrb_ram),
    .i_DATA_FROM_RAM    (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    end else begin
      if (write_ram) begin
        for (int b = 0; b < 4; b++)
          if (wstrb_ram[b]) ram[sample_index][b*8 +: 8] <= sample_data[b*8 +: 8];
        wr_count <= wr_count + 1;
      end
      if (read_ram) begin
        ram_rdata <= ram[sample_index];
        rd_count  <= rd_count + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] base, input int last_at);
    bit hs;
    int start_wr;
    start_wr       = wr_count;
    wb_loaded_cnt  = 0;
    wb_loaded_beat = -1;
    wb_bresp       = 2'b11;
    wb_bid         = 2'b11;
    @(posedge clk); #1;
    axi.i_AWADDR = addr; axi.i_AWLEN = len; axi.i_AWSIZE = 3'd2;
    axi.i_AWBURST = burst; axi.i_AWID = 2'd1; axi.i_AWVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = axi.o_AWREADY;
      @(posedge clk); #1;
    end
    axi.i_AWVALID = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL aw_handshake: no AWREADY within 20 clks"); end
    for (int b = 0; b <= int'(len); b++) begin
      axi.i_WVALID = 1'b1; axi.i_WDATA = base + 32'(b); axi.i_WSTRB = 4'hF; axi.i_WLAST = (b == last_at);
      @(negedge clk);
      if (data_loaded) begin wb_loaded_cnt++; wb_loaded_beat = b; end
      @(posedge clk); #1;
    end
    axi.i_WVALID = 1'b0; axi.i_WLAST = 1'b0; axi.i_BREADY = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      if (axi.o_BVALID) begin hs = 1'b1; wb_bresp = axi.o_BRESP; wb_bid = axi.o_BID; end
      @(posedge clk); #1;
    end
    axi.i_BREADY = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL b_handshake: no BVALID within 20 clks"); end
    wb_writes = wr_count - start_wr;
  endtask

  task automatic read_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] pat);
    bit hs, done;
    int start_rd, outs;
    start_rd   = rd_count;
    rb_n       = 0;
    rb_max_out = 0;
    @(posedge clk); #1;
    axi.i_ARADDR = addr; axi.i_ARLEN = len; axi.i_ARSIZE = 3'd2;
    axi.i_ARBURST = burst; axi.i_ARID = 2'd2; axi.i_ARVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = axi.o_ARREADY;
      @(posedge clk); #1;
    end
    axi.i_ARVALID = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL ar_handshake: no ARREADY within 20 clks"); end
    done = 1'b0;
    for (int k = 0; k < 200 && !done && hs; k++) begin
      axi.i_RREADY = pat[k % 4];
      @(negedge clk);
      outs = (rd_count - start_rd) + int'(read_ram) - rb_n - int'(axi.o_RVALID && axi.i_RREADY);
      if (outs > rb_max_out) rb_max_out = outs;
      if (axi.o_RVALID && axi.i_RREADY && rb_n < 16) begin
        rb_data[rb_n] = axi.o_RDATA; rb_last[rb_n] = axi.o_RLAST;
        rb_resp[rb_n] = axi.o_RRESP; rb_id[rb_n] = axi.o_RID; rb_cyc[rb_n] = k;
        rb_n++;
        if (axi.o_RLAST) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    axi.i_RREADY = 1'b0;
    if (hs && !done) begin checks++; errors++; $display("FAIL r_stream: RLAST not seen within 200 clks"); end
    rb_reads = rd_count - start_rd;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ram_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (axi.o_AWREADY !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", axi.o_AWREADY); end
    checks++; if (axi.o_BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", axi.o_BVALID); end
    checks++; if (axi.o_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", axi.o_RVALID); end
    checks++; if (write_ram !== 1'b0 || read_ram !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b%b want 00", write_ram, read_ram); end
    @(posedge clk); #1;
    rstn = 1'b1; ram_clr = 1'b0;
    @(negedge clk);
    checks++; if (axi.o_AWREADY !== 1'b1) begin errors++; $display("FAIL idle_awready got %b want 1", axi.o_AWREADY); end
    checks++; if (axi.o_ARREADY !== 1'b0) begin errors++; $display("FAIL idle_arready got %b want 0", axi.o_ARREADY); end
    checks++; if (axi.o_BRESP !== 2'b00 || axi.o_RDATA !== 32'h0) begin errors++; $display("FAIL rst_resp_data bresp %b rdata %h want 00/0", axi.o_BRESP, axi.o_RDATA); end
  endtask

  task automatic test_incr_write();
    logic [31:0] exp;
    write_burst(12'h010, 8'd3, BURST_INCR, 32'd1, 3);
    checks++; if (wb_bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b want 00", wb_bresp); end
    checks++; if (wb_bid !== 2'd1) begin errors++; $display("FAIL incr_bid got %0d want 1", wb_bid); end
    checks++; if (wb_loaded_cnt != 1 || wb_loaded_beat != 3) begin errors++; $display("FAIL incr_loaded cnt %0d beat %0d want 1/3", wb_loaded_cnt, wb_loaded_beat); end
    checks++; if (wb_writes != 4) begin errors++; $display("FAIL incr_nwrites got %0d want 4", wb_writes); end
    for (int i = 0; i < 4; i++) begin
      exp = 32'(i + 1);
      checks++; if (ram[4 + i] !== exp) begin errors++; $display("FAIL incr_ram[%0d] got %h want %h", 4 + i, ram[4 + i], exp); end
    end
  endtask

  task automatic test_read_gate();
    bit seen;
    @(posedge clk); #1;
    axi.i_ARADDR = 12'h010; axi.i_ARLEN = 8'd3; axi.i_ARBURST = BURST_INCR; axi.i_ARVALID = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (axi.o_ARREADY) seen = 1'b1; @(posedge clk); #1; end
    axi.i_ARVALID = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ar_before_calc got ARREADY=1 want 0"); end
    calc_end = 1'b1; @(posedge clk); #1; calc_end = 1'b0;
    read_burst(12'h010, 8'd3, BURST_INCR, 4'b1111);
    checks++; if (rb_n != 4) begin errors++; $display("FAIL rd_nbeats got %0d want 4", rb_n); end
    for (int i = 0; i < rb_n && i < 4; i++) begin
      checks++;
      if (rb_data[i] !== 32'(i + 1) || rb_last[i] !== (i == 3) || rb_resp[i] !== 2'b00 || rb_id[i] !== 2'd2) begin
        errors++; $display("FAIL rd_beat%0d data %h last %b resp %b id %0d want %h/%b/00/2", i, rb_data[i], rb_last[i], rb_resp[i], rb_id[i], i + 1, i == 3);
      end
    end
    checks++; if (rb_n == 4 && rb_cyc[3] - rb_cyc[0] != 3) begin errors++; $display("FAIL rd_throughput span %0d clks want 3", rb_cyc[3] - rb_cyc[0]); end
  endtask

  task automatic test_rready_toggle();
    read_burst(12'h010, 8'd3, BURST_INCR, 4'b1001);
    checks++; if (rb_n != 4) begin errors++; $display("FAIL tog_nbeats got %0d want 4", rb_n); end
    for (int i = 0; i < rb_n && i < 4; i++) begin
      checks++; if (rb_data[i] !== 32'(i + 1)) begin errors++; $display("FAIL tog_beat%0d got %h want %h", i, rb_data[i], i + 1); end
    end
    checks++; if (rb_reads != 4) begin errors++; $display("FAIL tog_nreads got %0d want 4", rb_reads); end
    checks++; if (rb_max_out > 2) begin errors++; $display("FAIL tog_outstanding got %0d want <=2", rb_max_out); end
  endtask

  task automatic test_error_read();
    read_burst(12'h080, 8'd1, BURST_WRAP, 4'b1111);
    checks++; if (rb_n != 2) begin errors++; $display("FAIL errrd_nbeats got %0d want 2", rb_n); end
    for (int i = 0; i < rb_n && i < 2; i++) begin
      checks++;
      if (rb_data[i] !== 32'h0 || rb_resp[i] !== 2'b10 || rb_last[i] !== (i == 1)) begin
        errors++; $display("FAIL errrd_beat%0d data %h resp %b last %b want 0/10/%b", i, rb_data[i], rb_resp[i], rb_last[i], i == 1);
      end
    end
    checks++; if (rb_reads != 0) begin errors++; $display("FAIL errrd_ram_reads got %0d want 0", rb_reads); end
  endtask

  task automatic test_fixed();
    write_burst(12'h040, 8'd2, BURST_FIXED, 32'hA, 2);
    checks++; if (ram[16] !== 32'hC) begin errors++; $display("FAIL fixed_ram16 got %h want 0000000c", ram[16]); end
    checks++; if (ram[17] !== 32'h0 || ram[18] !== 32'h0) begin errors++; $display("FAIL fixed_neighbours got %h %h want 0 0", ram[17], ram[18]); end
    checks++; if (wb_bresp !== 2'b00 || wb_writes != 3) begin errors++; $display("FAIL fixed_resp bresp %b writes %0d want 00/3", wb_bresp, wb_writes); end
  endtask

  task automatic test_wrap_write();
    write_burst(12'h080, 8'd1, BURST_WRAP, 32'h77, 1);
    checks++; if (wb_writes != 0) begin errors++; $display("FAIL wrap_writes got %0d want 0", wb_writes); end
    checks++; if (wb_bresp !== 2'b10) begin errors++; $display("FAIL wrap_bresp got %b want 10", wb_bresp); end
    checks++; if (wb_loaded_cnt != 0) begin errors++; $display("FAIL wrap_loaded got %0d want 0", wb_loaded_cnt); end
  endtask

  task automatic test_early_wlast();
    write_burst(12'h100, 8'd3, BURST_INCR, 32'h21, 1);
    checks++; if (wb_bresp !== 2'b10) begin errors++; $display("FAIL early_bresp got %b want 10", wb_bresp); end
    checks++; if (wb_loaded_cnt != 0) begin errors++; $display("FAIL early_loaded got %0d want 0", wb_loaded_cnt); end
    checks++; if (ram[65] !== 32'h22 || ram[66] !== 32'h0) begin errors++; $display("FAIL early_ram got %h %h want 22 0", ram[65], ram[66]); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    axi.i_AWADDR = 12'h200; axi.i_AWLEN = 8'd3; axi.i_AWBURST = BURST_INCR; axi.i_AWVALID = 1'b1;
    @(posedge clk); #1;
    axi.i_AWVALID = 1'b0;
    axi.i_WVALID = 1'b1; axi.i_WDATA = 32'h55; axi.i_WSTRB = 4'hF; axi.i_WLAST = 1'b0;
    @(posedge clk); #1; axi.i_WDATA = 32'h56;
    @(posedge clk); #1; axi.i_WDATA = 32'h57; rstn = 1'b0;
    @(negedge clk);
    checks++; if (axi.o_WREADY !== 1'b0 || write_ram !== 1'b0) begin errors++; $display("FAIL midrst_outputs wready %b write %b want 0 0", axi.o_WREADY, write_ram); end
    @(posedge clk); #1; rstn = 1'b1; axi.i_WVALID = 1'b0;
    @(negedge clk);
    checks++; if (axi.o_AWREADY !== 1'b1 || axi.o_WREADY !== 1'b0) begin errors++; $display("FAIL midrst_idle awready %b wready %b want 1 0", axi.o_AWREADY, axi.o_WREADY); end
    repeat (3) @(negedge clk);
    checks++; if (axi.o_BVALID !== 1'b0) begin errors++; $display("FAIL midrst_bvalid got %b want 0", axi.o_BVALID); end
    checks++; if (ram[128] !== 32'h55 || ram[129] !== 32'h56 || ram[130] !== 32'h0) begin errors++; $display("FAIL midrst_ram got %h %h %h want 55 56 0", ram[128], ram[129], ram[130]); end
  endtask

`ifdef FFT_BRIDGE_RANGE_CHECK_EN
  task automatic test_range_check();
    samples_number = 11'd6;
    write_burst(12'h010, 8'd3, BURST_INCR, 32'h11, 3);
    samples_number = 11'd1024;
    checks++; if (ram[4] !== 32'h11 || ram[5] !== 32'h12) begin errors++; $display("FAIL range_inside got %h %h want 11 12", ram[4], ram[5]); end
    checks++; if (ram[6] !== 32'h3 || ram[7] !== 32'h4) begin errors++; $display("FAIL range_outside got %h %h want 3 4", ram[6], ram[7]); end
    checks++; if (wb_bresp !== 2'b10 || wb_loaded_cnt != 0) begin errors++; $display("FAIL range_resp bresp %b loaded %0d want 10/0", wb_bresp, wb_loaded_cnt); end
  endtask
`endif

  initial begin
    rstn = 1'b0; ram_clr = 1'b1; calc_end = 1'b0; samples_number = 11'd1024;
    axi.i_AWADDR = '0; axi.i_AWLEN = '0; axi.i_AWSIZE = 3'd2; axi.i_AWBURST = 2'b01; axi.i_AWID = '0; axi.i_AWVALID = 1'b0;
    axi.i_WDATA = '0; axi.i_WSTRB = '0; axi.i_WVALID = 1'b0; axi.i_WLAST = 1'b0; axi.i_BREADY = 1'b0;
    axi.i_ARADDR = '0; axi.i_ARLEN = '0; axi.i_ARSIZE = 3'd2; axi.i_ARBURST = 2'b01; axi.i_ARID = '0; axi.i_ARVALID = 1'b0;
    axi.i_RREADY = 1'b0;
    test_reset();
    test_incr_write();
    test_read_gate();
    test_rready_toggle();
    test_error_read();
    test_fixed();
    test_wrap_write();
    test_early_wlast();
    test_reset_mid();
`ifdef FFT_BRIDGE_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
